skeleton_phase_ctrl: RTL and testbench
======================================

// Module: skeleton_phase_ctrl
// PURPOSE
//   Sequences one instruction through the multi-phase 32-bit processor skeleton on a single clock.
//   Issues one-cycle enable strobes in order: imem fetch, regfile read, dmem access, processor commit.
//   Stretches reset to the core, supports run/halt/single-step control and waits on dmem handshakes.
//   Counts retired instructions and flags dmem timeouts.
// PARAMETERS
//   RESET_HOLD   8    cycles core_reset_n stays low after reset deasserts (>=1)
//   MEM_TIMEOUT  15   max MEM_WAIT cycles before timeout error (>=1)
//   CNT_W        32   width of retired-instruction counter
// PORTS
//   clock         in   1      single system clock, rising edge
//   reset         in   1      asynchronous, active-low reset
//   run           in   1      level: 1 = free-run, 0 = halt at the next instruction boundary
//   step          in   1      one-cycle pulse: execute exactly one instruction while halted
//   halt_req      in   1      processor halt instruction; sampled in COMMIT
//   dmem_ready    in   1      dmem completes its access this cycle
//   core_reset_n  out  1      registered, stretched active-low reset to the core
//   imem_en       out  1      fetch strobe
//   regfile_en    out  1      regfile read strobe
//   dmem_en       out  1      dmem access strobe; held high through MEM_WAIT
//   proc_en       out  1      commit strobe: PC update plus regfile writeback
//   halted        out  1      1 in HALT state
//   mem_err       out  1      sticky dmem timeout flag
//   retired       out  CNT_W  count of committed instructions
// BEHAVIOUR
//   All outputs are registered. On reset low: state=RST, core_reset_n=0, all enables=0,
//     halted=0, mem_err=0, retired=0. Reset low mid-sequence aborts immediately; nothing retires.
//   States: RST, HALT, FETCH, READ, MEM, MEM_WAIT, COMMIT.
//   RST: hold counter counts RESET_HOLD cycles after reset rises. core_reset_n goes 1 on the
//     final count. Next state: FETCH if run=1, else HALT.
//   HALT: halted=1. Go to FETCH if run=1 or step=1. step with run=1 is ignored.
//   FETCH: imem_en=1 for 1 cycle -> READ. READ: regfile_en=1 for 1 cycle -> MEM.
//   MEM: dmem_en=1. If dmem_ready=1 in the same cycle -> COMMIT, else -> MEM_WAIT.
//   MEM_WAIT: dmem_en stays 1 and the wait counter increments. dmem_ready=1 -> COMMIT.
//     If the wait count reaches MEM_TIMEOUT: set mem_err=1 (sticky until reset), -> HALT.
//   COMMIT: proc_en=1 for 1 cycle and retired += 1 (wraps modulo 2^CNT_W).
//     Next state: HALT if halt_req=1, or run=0, or the instruction was a single step;
//     else FETCH.
//   Minimum latency: 4 cycles per instruction (FETCH, READ, MEM with ready, COMMIT).
//   Enable strobes are mutually exclusive. Exactly one strobe is high in each non-RST,
//     non-HALT cycle.
//   run deasserted mid-instruction: the current instruction still completes through COMMIT.
//   halt_req is ignored outside COMMIT. dmem_ready is ignored outside MEM and MEM_WAIT.
//   step is edge-agnostic: a step pulse wider than one cycle still executes exactly one
//     instruction, because halted is re-entered and step must be seen again from HALT.
// TESTING
//   1. Hold reset low 3 cycles, release, run=1 -> core_reset_n rises after exactly 8 cycles;
//      first imem_en 1 cycle later.
//   2. run=1, dmem_ready tied 1 -> enables rotate imem/reg/dmem/proc with period 4;
//      retired=10 after 40 cycles.
//   3. dmem_ready low 3 cycles in MEM -> dmem_en high 4 cycles, proc_en on the following
//      cycle, retired+1.
//   4. dmem_ready held 0 -> mem_err=1 after 15 MEM_WAIT cycles, halted=1, retired unchanged.
//   5. run=0, 3 step pulses -> exactly 3 proc_en strobes, halted=1 between each, retired=3.
//   6. Reset low during MEM_WAIT, and halt_req=1 in COMMIT -> all outputs return to reset
//      values at once; halt_req case halts with retired incremented.

Source files
------------

// File: rtl/skeleton_phase_ctrl.sv
// Phase sequencer for the multi-phase 32-bit processor skeleton.
// Walks one instruction at a time through fetch, regfile read, dmem access
// and commit, each phase announced by a registered one-cycle enable strobe.
// Also stretches reset to the core, implements run/halt/single-step control,
// waits on dmem handshakes with a timeout and counts retired instructions.
module skeleton_phase_ctrl #(
  parameter int RESET_HOLD  = 8,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             run,
  input  logic             step,
  input  logic             halt_req,
  input  logic             dmem_ready,
  output logic             core_reset_n,
  output logic             imem_en,
  output logic             regfile_en,
  output logic             dmem_en,
  output logic             proc_en,
  output logic             halted,
  output logic             mem_err,
  output logic [CNT_W-1:0] retired
);

  localparam int HOLD_W = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
  localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_HOLD - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_RST      = 3'd0,
    ST_HALT     = 3'd1,
    ST_FETCH    = 3'd2,
    ST_READ     = 3'd3,
    ST_MEM      = 3'd4,
    ST_MEM_WAIT = 3'd5,
    ST_COMMIT   = 3'd6
  } state_t;

  state_t            state_q, state_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              step_mode_q, step_mode_d;
  logic              core_reset_n_q, core_reset_n_d;
  logic              mem_err_q, mem_err_d;
  logic              imem_en_q, imem_en_d;
  logic              regfile_en_q, regfile_en_d;
  logic              dmem_en_q, dmem_en_d;
  logic              proc_en_q, proc_en_d;
  logic              halted_q, halted_d;
  logic [CNT_W-1:0]  retired_q, retired_d;

  // State register plus every registered output; async reset returns all to idle values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q        <= ST_RST;
      hold_cnt_q     <= '0;
      wait_cnt_q     <= '0;
      step_mode_q    <= 1'b0;
      core_reset_n_q <= 1'b0;
      mem_err_q      <= 1'b0;
      imem_en_q      <= 1'b0;
      regfile_en_q   <= 1'b0;
      dmem_en_q      <= 1'b0;
      proc_en_q      <= 1'b0;
      halted_q       <= 1'b0;
      retired_q      <= '0;
    end else begin
      state_q        <= state_d;
      hold_cnt_q     <= hold_cnt_d;
      wait_cnt_q     <= wait_cnt_d;
      step_mode_q    <= step_mode_d;
      core_reset_n_q <= core_reset_n_d;
      mem_err_q      <= mem_err_d;
      imem_en_q      <= imem_en_d;
      regfile_en_q   <= regfile_en_d;
      dmem_en_q      <= dmem_en_d;
      proc_en_q      <= proc_en_d;
      halted_q       <= halted_d;
      retired_q      <= retired_d;
    end
  end

  // Next-state logic: phase sequencing, reset stretch, dmem wait/timeout, step tracking.
  always_comb begin
    state_d        = state_q;
    hold_cnt_d     = hold_cnt_q;
    wait_cnt_d     = wait_cnt_q;
    step_mode_d    = step_mode_q;
    core_reset_n_d = core_reset_n_q;
    mem_err_d      = mem_err_q;
    case (state_q)
      ST_RST: begin
        // Core reset is released on the final hold count; the first phase
        // decision is taken one cycle later so the core sees reset gone first.
        if (!core_reset_n_q) begin
          if (hold_cnt_q == HOLD_LAST) begin
            core_reset_n_d = 1'b1;
          end else begin
            hold_cnt_d = hold_cnt_q + HOLD_W'(1);
          end
        end else begin
          step_mode_d = 1'b0;
          state_d     = run ? ST_FETCH : ST_HALT;
        end
      end
      ST_HALT: begin
        // A step while running is meaningless, so it only counts when run=0.
        if (run || step) begin
          step_mode_d = !run;
          state_d     = ST_FETCH;
        end
      end
      ST_FETCH: state_d = ST_READ;
      ST_READ:  state_d = ST_MEM;
      ST_MEM: begin
        wait_cnt_d = '0;
        state_d    = dmem_ready ? ST_COMMIT : ST_MEM_WAIT;
      end
      ST_MEM_WAIT: begin
        // A ready arriving on the last allowed wait cycle still wins over the timeout.
        if (dmem_ready) begin
          state_d = ST_COMMIT;
        end else if (wait_cnt_q == WAIT_LAST) begin
          mem_err_d = 1'b1;
          state_d   = ST_HALT;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end
      ST_COMMIT: begin
        state_d = (halt_req || !run || step_mode_q) ? ST_HALT : ST_FETCH;
      end
      default: state_d = ST_RST;
    endcase
  end

  // Output logic: strobes decoded from the next state so they are registered yet phase-aligned.
  always_comb begin
    imem_en_d    = (state_d == ST_FETCH);
    regfile_en_d = (state_d == ST_READ);
    dmem_en_d    = (state_d == ST_MEM) || (state_d == ST_MEM_WAIT);
    proc_en_d    = (state_d == ST_COMMIT);
    halted_d     = (state_d == ST_HALT);
    retired_d    = retired_q;
    if (state_q == ST_COMMIT) begin
      retired_d = retired_q + CNT_W'(1);
    end
  end

  assign core_reset_n = core_reset_n_q;
  assign imem_en      = imem_en_q;
  assign regfile_en   = regfile_en_q;
  assign dmem_en      = dmem_en_q;
  assign proc_en      = proc_en_q;
  assign halted       = halted_q;
  assign mem_err      = mem_err_q;
  assign retired      = retired_q;

endmodule

// File: tb/tb_skeleton_phase_ctrl.sv
// Bench for skeleton_phase_ctrl: a table of cycle vectors, hand-written
// corner-case sequences and a long random run, all checked against an
// instruction-progress model kept in this file.
module tb_skeleton_phase_ctrl;

  localparam int RESET_HOLD  = 8;
  localparam int MEM_TIMEOUT = 15;
  localparam int CNT_W       = 32;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             run = 1'b0;
  logic             step = 1'b0;
  logic             halt_req = 1'b0;
  logic             dmem_ready = 1'b0;
  logic             core_reset_n;
  logic             imem_en;
  logic             regfile_en;
  logic             dmem_en;
  logic             proc_en;
  logic             halted;
  logic             mem_err;
  logic [CNT_W-1:0] retired;

  int n_checks = 0;
  int n_fail   = 0;

  skeleton_phase_ctrl #(
    .RESET_HOLD (RESET_HOLD),
    .MEM_TIMEOUT(MEM_TIMEOUT),
    .CNT_W      (CNT_W)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .run         (run),
    .step        (step),
    .halt_req    (halt_req),
    .dmem_ready  (dmem_ready),
    .core_reset_n(core_reset_n),
    .imem_en     (imem_en),
    .regfile_en  (regfile_en),
    .dmem_en     (dmem_en),
    .proc_en     (proc_en),
    .halted      (halted),
    .mem_err     (mem_err),
    .retired     (retired)
  );

  always #5 clock = ~clock;

  // Reference model: progress of the current instruction.
  // m_boot counts clock edges since reset release; m_idle means parked halted;
  // m_slot is the cycle index inside the instruction (0 fetch, 1 read, 2.. dmem cycles);
  // m_commit marks the commit cycle.
  int               m_boot;
  bit               m_idle;
  bit               m_commit;
  bit               m_single;
  bit               m_err;
  int               m_slot;
  logic [CNT_W-1:0] m_retired;

  function automatic void model_reset();
    m_boot    = 0;
    m_idle    = 1'b0;
    m_commit  = 1'b0;
    m_single  = 1'b0;
    m_err     = 1'b0;
    m_slot    = 0;
    m_retired = '0;
  endfunction

  function automatic void model_edge(input bit r, input bit s, input bit h, input bit d);
    if (m_boot <= RESET_HOLD) begin
      if (m_boot == RESET_HOLD) begin
        m_idle   = !r;
        m_slot   = 0;
        m_commit = 1'b0;
        m_single = 1'b0;
      end
      m_boot++;
    end else if (m_idle) begin
      if (r || s) begin
        m_idle   = 1'b0;
        m_slot   = 0;
        m_single = !r;
      end
    end else if (m_commit) begin
      m_retired = m_retired + 1;
      m_commit  = 1'b0;
      if (h || !r || m_single) m_idle = 1'b1;
      else                     m_slot = 0;
    end else if (m_slot < 2) begin
      m_slot++;
    end else if (d) begin
      m_commit = 1'b1;
    end else if (m_slot - 2 == MEM_TIMEOUT) begin
      m_err  = 1'b1;
      m_idle = 1'b1;
    end else begin
      m_slot++;
    end
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    bit in_boot;
    bit busy;
    in_boot = (m_boot <= RESET_HOLD);
    busy    = !in_boot && !m_idle;
    chk("model.core_reset_n", core_reset_n, m_boot >= RESET_HOLD);
    chk("model.imem_en",      imem_en,      busy && !m_commit && m_slot == 0);
    chk("model.regfile_en",   regfile_en,   busy && !m_commit && m_slot == 1);
    chk("model.dmem_en",      dmem_en,      busy && !m_commit && m_slot >= 2);
    chk("model.proc_en",      proc_en,      busy && m_commit);
    chk("model.halted",       halted,       !in_boot && m_idle);
    chk("model.mem_err",      mem_err,      m_err);
    chk("model.retired",      retired,      m_retired);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, ".core_reset_n"}, core_reset_n, 0);
    chk({tag, ".enables"}, {imem_en, regfile_en, dmem_en, proc_en}, 0);
    chk({tag, ".halted"}, halted, 0);
    chk({tag, ".mem_err"}, mem_err, 0);
    chk({tag, ".retired"}, retired, 0);
  endtask

  // One clock: drive inputs, advance the model at the edge, compare on the falling edge.
  task automatic apply(input logic r, input logic s, input logic h, input logic d);
    run        = r;
    step       = s;
    halt_req   = h;
    dmem_ready = d;
    @(posedge clock);
    model_edge(r, s, h, d);
    @(negedge clock);
    compare_model();
  endtask

  // Called on a falling edge: asserts reset mid-cycle, checks the immediate effect,
  // holds it for some edges and releases it on a falling edge.
  task automatic do_reset(input int low_edges, input string tag);
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    check_reset_vals(tag);
    repeat (low_edges) @(posedge clock);
    @(negedge clock);
    compare_model();
    reset = 1'b1;
  endtask

  typedef struct {
    logic        r;
    logic        s;
    logic        h;
    logic        d;
    logic [3:0]  strobes;   // {imem, regfile, dmem, proc}
    logic        hlt;
    logic [31:0] ret;
  } vec_t;

  vec_t tbl[8];

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int         boot_len;
    int         dmem_cycles;
    int         procs;
    int         waits;
    logic [3:0] exp_strobe;
    logic [3:0] one_hot;
    logic [CNT_W-1:0] ret0;
    int         mode;
    bit         rr, ss, hh, dd;

    // Wait-in-MEM sequence starting from a FETCH cycle with retired=10.
    tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b1, 4'b0100, 1'b0, 32'd10};
    tbl[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'b0010, 1'b0, 32'd10};
    tbl[2] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'b0010, 1'b0, 32'd10};
    tbl[3] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'b0010, 1'b0, 32'd10};
    tbl[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'b0010, 1'b0, 32'd10};
    tbl[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 4'b0001, 1'b0, 32'd10};
    tbl[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b1, 32'd11};
    tbl[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b1, 32'd11};

    model_reset();
    @(negedge clock);

    // Reset stretch: core_reset_n after RESET_HOLD edges, fetch one edge later.
    run        = 1'b1;
    dmem_ready = 1'b1;
    do_reset(3, "por");
    boot_len = 0;
    for (int i = 1; i <= 20; i++) begin
      apply(1, 0, 0, 1);
      if (core_reset_n === 1'b1) begin
        boot_len = i;
        break;
      end
    end
    chk("boot.delay", boot_len, RESET_HOLD);
    chk("boot.no_fetch_yet", imem_en, 0);
    apply(1, 0, 0, 1);
    chk("boot.first_fetch", imem_en, 1);

    // Free run with ready tied high: period-4 rotation.
    one_hot = 4'b1000;
    for (int k = 1; k <= 40; k++) begin
      apply(1, 0, 0, 1);
      exp_strobe = one_hot >> (k % 4);
      chk("rotate.strobes", {imem_en, regfile_en, dmem_en, proc_en}, exp_strobe);
    end
    chk("rotate.retired", retired, 10);

    // Vector table: dmem stalls three cycles, then commit and halt on run=0.
    dmem_cycles = 0;
    for (int v = 0; v < 8; v++) begin
      apply(tbl[v].r, tbl[v].s, tbl[v].h, tbl[v].d);
      chk("table.strobes", {imem_en, regfile_en, dmem_en, proc_en}, tbl[v].strobes);
      chk("table.halted", halted, tbl[v].hlt);
      chk("table.retired", retired, tbl[v].ret);
      if (dmem_en) dmem_cycles++;
    end
    chk("table.dmem_cycles", dmem_cycles, 4);

    // Single stepping from a fresh reset with run=0; the second pulse is two cycles wide.
    run = 1'b0;
    do_reset(2, "step_rst");
    for (int i = 0; i < 20; i++) begin
      apply(0, 0, 0, 1);
      if (halted === 1'b1) break;
    end
    chk("step.boot_halted", halted, 1);
    procs = 0;
    for (int s = 0; s < 3; s++) begin
      apply(0, 1, 0, 1);
      chk("step.fetch", imem_en, 1);
      if (s == 1) apply(0, 1, 0, 1);
      for (int i = 0; i < 12; i++) begin
        apply(0, 0, 0, 1);
        if (proc_en) procs++;
        if (halted === 1'b1) break;
      end
      chk("step.halted_between", halted, 1);
      apply(0, 0, 0, 1);
      chk("step.stays_halted", {halted, imem_en}, 2'b10);
    end
    chk("step.proc_count", procs, 3);
    chk("step.retired", retired, 3);

    // dmem timeout: 15 wait cycles, then sticky error and halt.
    ret0 = retired;
    apply(1, 0, 0, 0);
    apply(1, 0, 0, 0);
    apply(1, 0, 0, 0);
    chk("timeout.in_mem", dmem_en, 1);
    waits = 0;
    for (int i = 1; i <= 30; i++) begin
      apply(1, 0, 0, 0);
      if (halted === 1'b1) break;
      chk("timeout.no_early_err", mem_err, 0);
      waits++;
    end
    chk("timeout.wait_cycles", waits, MEM_TIMEOUT);
    chk("timeout.mem_err", mem_err, 1);
    chk("timeout.dmem_dropped", dmem_en, 0);
    chk("timeout.retired", retired, ret0);
    for (int i = 0; i < 5; i++) apply(1, 0, 0, 1);
    chk("timeout.sticky", mem_err, 1);
    chk("timeout.next_retires", retired, ret0 + 1);

    // Reset during MEM_WAIT aborts at once.
    apply(1, 0, 0, 0);
    apply(1, 0, 0, 0);
    apply(1, 0, 0, 0);
    apply(1, 0, 0, 0);
    chk("abort.in_wait", dmem_en, 1);
    run = 1'b1;
    do_reset(2, "abort");

    // halt_req is ignored until COMMIT, where it halts after retiring.
    for (int i = 0; i < 20; i++) begin
      apply(1, 0, 1, 1);
      if (imem_en === 1'b1) break;
    end
    chk("haltreq.fetch", imem_en, 1);
    apply(1, 0, 1, 1);
    apply(1, 0, 1, 1);
    apply(1, 0, 1, 1);
    chk("haltreq.commit", proc_en, 1);
    apply(1, 0, 1, 1);
    chk("haltreq.halted", halted, 1);
    chk("haltreq.retired", retired, 1);
    chk("haltreq.no_strobe", {imem_en, regfile_en, dmem_en, proc_en}, 0);

    // Randomized run against the model, with stall-heavy phases and rare resets.
    mode = 0;
    for (int c = 0; c < 3000; c++) begin
      if (c % 250 == 0) mode = $urandom_range(0, 2);
      rr = (mode == 1) ? ($urandom % 6 == 0) : ($urandom % 8 != 0);
      ss = ($urandom % 5 == 0);
      hh = ($urandom % 10 == 0);
      dd = (mode == 2) ? ($urandom % 20 == 0) : ($urandom % 3 != 0);
      if ($urandom % 600 == 0) do_reset($urandom_range(1, 3), "rand_rst");
      apply(rr, ss, hh, dd);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
